// File: rtl/display_timings_pkg.sv
// Shared display mode table: raster timing sets plus the matching
// gradient step, so the timing block and the test cards stay in agreement.
package display_timings_pkg;

   typedef enum logic [1:0] {
      MODE_480P60,
      MODE_720P60,
      MODE_1080P60
   } mode_e;

   typedef struct packed {
      int   hRes;
      int   vRes;
      int   hFp;
      int   hSync;
      int   hBp;
      int   vFp;
      int   vSync;
      int   vBp;
      logic hPol;
      logic vPol;
      int   step;
   } modeCfg_t;

   localparam modeCfg_t MODE_480P60_CFG  = '{640, 480, 16, 96, 48, 10, 2, 33, 1'b0, 1'b0, 2};
   localparam modeCfg_t MODE_720P60_CFG  = '{1280, 720, 110, 40, 220, 5, 5, 20, 1'b1, 1'b1, 2};
   localparam modeCfg_t MODE_1080P60_CFG = '{1920, 1080, 88, 44, 148, 4, 5, 36, 1'b1, 1'b1, 3};

   function automatic modeCfg_t modeCfg(input mode_e mode);
      case (mode)
         MODE_720P60:  return MODE_720P60_CFG;
         MODE_1080P60: return MODE_1080P60_CFG;
         default:      return MODE_480P60_CFG;
      endcase
   endfunction

   // Inclusive signed window test shared by the horizontal and vertical sync decode.
   function automatic logic inWindow(input logic signed [15:0] pos,
                                     input logic signed [15:0] first,
                                     input logic signed [15:0] last);
      return (pos >= first) && (pos <= last);
   endfunction

endpackage

// File: rtl/display_timings_if.sv
// Pixel strobe in, raster timing out; master is the timing generator,
// slave is the downstream card / encoder.
interface display_timings_if;
   logic               i_en;
   logic               o_hs;
   logic               o_vs;
   logic               o_de;
   logic               o_line;
   logic               o_frame;
   logic signed [15:0] o_h;
   logic signed [15:0] o_v;
   logic        [15:0] o_x;
   logic        [15:0] o_y;

   modport master (
      input  i_en,
      output o_hs, o_vs, o_de, o_line, o_frame, o_h, o_v, o_x, o_y
   );

   modport slave (
      output i_en,
      input  o_hs, o_vs, o_de, o_line, o_frame, o_h, o_v, o_x, o_y
   );
endinterface

// File: rtl/display_timings.sv
// Raster timing generator: signed h/v position counters starting in the
// blanking region, with sync, data-enable and line/frame strobes registered in step.
module display_timings
   import display_timings_pkg::*;
#(
   parameter int H_RES  = MODE_480P60_CFG.hRes,
   parameter int V_RES  = MODE_480P60_CFG.vRes,
   parameter int H_FP   = MODE_480P60_CFG.hFp,
   parameter int H_SYNC = MODE_480P60_CFG.hSync,
   parameter int H_BP   = MODE_480P60_CFG.hBp,
   parameter int V_FP   = MODE_480P60_CFG.vFp,
   parameter int V_SYNC = MODE_480P60_CFG.vSync,
   parameter int V_BP   = MODE_480P60_CFG.vBp,
   parameter int H_POL  = 0,
   parameter int V_POL  = 0
) (
   input  logic               i_pix_clk,
   input  logic               i_rst_n,
   display_timings_if.master  tim
);

   // Out-of-range timing sets must stop elaboration rather than wrap silently.
   if ((H_RES + H_FP + H_SYNC + H_BP) > 32767 || H_RES < 1 ||
       H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : gBadH
      $error("display_timings: horizontal timing parameters out of range");
   end
   if ((V_RES + V_FP + V_SYNC + V_BP) > 32767 || V_RES < 1 ||
       V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : gBadV
      $error("display_timings: vertical timing parameters out of range");
   end

   localparam logic signed [15:0] H_STA    = 16'(-(H_FP + H_SYNC + H_BP));
   localparam logic signed [15:0] H_END    = 16'(H_RES - 1);
   localparam logic signed [15:0] HS_FIRST = 16'(-(H_SYNC + H_BP));
   localparam logic signed [15:0] HS_LAST  = 16'(-H_BP - 1);
   localparam logic signed [15:0] V_STA    = 16'(-(V_FP + V_SYNC + V_BP));
   localparam logic signed [15:0] V_END    = 16'(V_RES - 1);
   localparam logic signed [15:0] VS_FIRST = 16'(-(V_SYNC + V_BP));
   localparam logic signed [15:0] VS_LAST  = 16'(-V_BP - 1);
   localparam logic               HS_ON    = (H_POL != 0);
   localparam logic               VS_ON    = (V_POL != 0);

   logic signed [15:0] h_q, h_d;
   logic signed [15:0] v_q, v_d;
   logic               hs_q, vs_q, de_q, line_q, frame_q;
   logic        [15:0] x_q, y_q;

   // Next position; the vertical counter only steps when the line wraps.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (tim.i_en) begin
         if (h_q == H_END) begin
            h_d = H_STA;
            v_d = (v_q == V_END) ? V_STA : v_q + 16'sd1;
         end else begin
            h_d = h_q + 16'sd1;
         end
      end
   end

   // Decoding from h_d/v_d keeps every output aligned with o_h/o_v; when
   // stalled, h_d equals h_q so all outputs, strobes included, simply hold.
   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_q     <= H_STA;
         v_q     <= V_STA;
         hs_q    <= ~HS_ON;
         vs_q    <= ~VS_ON;
         de_q    <= 1'b0;
         line_q  <= 1'b1;
         frame_q <= 1'b1;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         hs_q    <= inWindow(h_d, HS_FIRST, HS_LAST) ? HS_ON : ~HS_ON;
         vs_q    <= inWindow(v_d, VS_FIRST, VS_LAST) ? VS_ON : ~VS_ON;
         de_q    <= (h_d >= 16'sd0) && (v_d >= 16'sd0);
         line_q  <= (h_d == H_STA);
         frame_q <= (h_d == H_STA) && (v_d == V_STA);
         x_q     <= (h_d >= 16'sd0) ? $unsigned(h_d) : 16'd0;
         y_q     <= (v_d >= 16'sd0) ? $unsigned(v_d) : 16'd0;
      end
   end

   assign tim.o_h     = h_q;
   assign tim.o_v     = v_q;
   assign tim.o_hs    = hs_q;
   assign tim.o_vs    = vs_q;
   assign tim.o_de    = de_q;
   assign tim.o_line  = line_q;
   assign tim.o_frame = frame_q;
   assign tim.o_x     = x_q;
   assign tim.o_y     = y_q;

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: a 640x480 instance and a tiny 4x2 instance,
// checked against a position model derived from the enabled-cycle count.
module tb_display_timings;

   typedef struct packed {
      logic signed [15:0] h;
      logic signed [15:0] v;
      logic        [15:0] x;
      logic        [15:0] y;
      logic               hs;
      logic               vs;
      logic               de;
      logic               line;
      logic               frame;
   } obs_t;

   typedef struct {
      bit en;
      int h;
      int v;
      bit hs;
      bit vs;
      bit de;
      bit line;
      bit frame;
   } vec_t;

   logic clk;
   logic rstA_n;
   logic rstB_n;
   int   checks;
   int   errors;
   int   nA;
   int   nB;
   obs_t qA[$];
   obs_t qB[$];
   vec_t vecB[10];

   display_timings_if ifA ();
   display_timings_if ifB ();

   display_timings dutA (
      .i_pix_clk (clk),
      .i_rst_n   (rstA_n),
      .tim       (ifA)
   );

   display_timings #(
      .H_RES(4), .V_RES(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
   ) dutB (
      .i_pix_clk (clk),
      .i_rst_n   (rstB_n),
      .tim       (ifB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Position n enabled cycles after reset, computed directly from n.
   function automatic obs_t model(input int n, input int hRes, input int vRes,
                                  input int hFp, input int hSync, input int hBp,
                                  input int vFp, input int vSync, input int vBp,
                                  input int hPol, input int vPol);
      obs_t e;
      int hTot = hRes + hFp + hSync + hBp;
      int vTot = vRes + vFp + vSync + vBp;
      int hSta = -(hFp + hSync + hBp);
      int vSta = -(vFp + vSync + vBp);
      int h    = hSta + (n % hTot);
      int v    = vSta + ((n / hTot) % vTot);
      bit hAct = (h >= hSta + hFp) && (h < hSta + hFp + hSync);
      bit vAct = (v >= vSta + vFp) && (v < vSta + vFp + vSync);
      e.h     = 16'(h);
      e.v     = 16'(v);
      e.x     = (h >= 0) ? 16'(h) : 16'd0;
      e.y     = (v >= 0) ? 16'(v) : 16'd0;
      e.hs    = hAct ? (hPol != 0) : (hPol == 0);
      e.vs    = vAct ? (vPol != 0) : (vPol == 0);
      e.de    = (h >= 0) && (v >= 0);
      e.line  = (h == hSta);
      e.frame = (h == hSta) && (v == vSta);
      return e;
   endfunction

   function automatic obs_t modelA(input int n);
      return model(n, 640, 480, 16, 96, 48, 10, 2, 33, 0, 0);
   endfunction

   function automatic obs_t modelB(input int n);
      return model(n, 4, 2, 1, 1, 1, 1, 1, 1, 1, 1);
   endfunction

   function automatic obs_t obsA();
      obs_t o;
      o = '{ifA.o_h, ifA.o_v, ifA.o_x, ifA.o_y, ifA.o_hs, ifA.o_vs, ifA.o_de, ifA.o_line, ifA.o_frame};
      return o;
   endfunction

   function automatic obs_t obsB();
      obs_t o;
      o = '{ifB.o_h, ifB.o_v, ifB.o_x, ifB.o_y, ifB.o_hs, ifB.o_vs, ifB.o_de, ifB.o_line, ifB.o_frame};
      return o;
   endfunction

   task automatic checkOutput(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b de=%b line=%b frame=%b expected h=%0d v=%0d x=%0d y=%0d hs=%b vs=%b de=%b line=%b frame=%b",
                  name, got.h, got.v, got.x, got.y, got.hs, got.vs, got.de, got.line, got.frame,
                  exp.h, exp.v, exp.x, exp.y, exp.hs, exp.vs, exp.de, exp.line, exp.frame);
      end
   endtask

   task automatic checkVal(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Drive one cycle of i_en, queue the expected state, compare after the edge.
   task automatic applyStimulusA(input bit en);
      obs_t exp;
      ifA.i_en = en;
      if (en) nA++;
      qA.push_back(modelA(nA));
      @(posedge clk);
      @(negedge clk);
      exp = qA.pop_front();
      checkOutput("seqA", obsA(), exp);
      ifA.i_en = 1'b0;
   endtask

   task automatic applyStimulusB(input bit en);
      obs_t exp;
      ifB.i_en = en;
      if (en) nB++;
      qB.push_back(modelB(nB));
      @(posedge clk);
      @(negedge clk);
      exp = qB.pop_front();
      checkOutput("seqB", obsB(), exp);
      ifB.i_en = 1'b0;
   endtask

   // Asynchronous assertion mid-cycle, release away from the active edge.
   task automatic resetA(input int hold);
      rstA_n = 1'b0;
      #1;
      checkOutput("rstA_async", obsA(), modelA(0));
      repeat (hold) @(negedge clk);
      checkOutput("rstA_hold", obsA(), modelA(0));
      rstA_n = 1'b1;
      nA = 0;
      qA.delete();
   endtask

   task automatic resetB(input int hold);
      rstB_n = 1'b0;
      #1;
      checkOutput("rstB_async", obsB(), modelB(0));
      repeat (hold) @(negedge clk);
      checkOutput("rstB_hold", obsB(), modelB(0));
      rstB_n = 1'b1;
      nB = 0;
      qB.delete();
   endtask

   initial begin
      int lastLine;
      int hsRun;
      int vsLow;
      int deLine0;
      int enCount;
      int lineCount;
      int frameCount;
      bit found;
      bit en;

      checks   = 0;
      errors   = 0;
      nA       = 0;
      nB       = 0;
      rstA_n   = 1'b0;
      rstB_n   = 1'b0;
      ifA.i_en = 1'b0;
      ifB.i_en = 1'b0;

      // Tiny-config walk from reset: h -3..3, v -3..1, hs/vs active-high at -2.
      vecB[0] = '{1, -2, -3, 1, 0, 0, 0, 0};
      vecB[1] = '{0, -2, -3, 1, 0, 0, 0, 0};
      vecB[2] = '{1, -1, -3, 0, 0, 0, 0, 0};
      vecB[3] = '{1,  0, -3, 0, 0, 0, 0, 0};
      vecB[4] = '{1,  1, -3, 0, 0, 0, 0, 0};
      vecB[5] = '{1,  2, -3, 0, 0, 0, 0, 0};
      vecB[6] = '{1,  3, -3, 0, 0, 0, 0, 0};
      vecB[7] = '{1, -3, -2, 0, 1, 0, 1, 0};
      vecB[8] = '{0, -3, -2, 0, 1, 0, 1, 0};
      vecB[9] = '{1, -2, -2, 1, 1, 0, 0, 0};

      repeat (5) @(negedge clk);
      checkOutput("resetA", obsA(), modelA(0));
      checkVal("resetA_h", ifA.o_h, -160);
      checkVal("resetA_v", ifA.o_v, -45);
      checkVal("resetA_hsvs", {ifA.o_hs, ifA.o_vs}, 3);
      checkVal("resetA_deframe", {ifA.o_de, ifA.o_frame, ifA.o_line}, 3);
      checkOutput("resetB", obsB(), modelB(0));
      checkVal("resetB_hsvs", {ifB.o_hs, ifB.o_vs}, 0);
      rstA_n = 1'b1;
      rstB_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         ifB.i_en = vecB[i].en;
         if (vecB[i].en) nB++;
         @(posedge clk);
         @(negedge clk);
         ifB.i_en = 1'b0;
         checks++;
         if (ifB.o_h != 16'(vecB[i].h) || ifB.o_v != 16'(vecB[i].v) ||
             ifB.o_hs != vecB[i].hs || ifB.o_vs != vecB[i].vs || ifB.o_de != vecB[i].de ||
             ifB.o_line != vecB[i].line || ifB.o_frame != vecB[i].frame) begin
            errors++;
            $display("[TB] FAIL vecB[%0d] got h=%0d v=%0d hs=%b vs=%b de=%b line=%b frame=%b expected h=%0d v=%0d hs=%b vs=%b de=%b line=%b frame=%b",
                     i, ifB.o_h, ifB.o_v, ifB.o_hs, ifB.o_vs, ifB.o_de, ifB.o_line, ifB.o_frame,
                     vecB[i].h, vecB[i].v, vecB[i].hs, vecB[i].vs, vecB[i].de, vecB[i].line, vecB[i].frame);
         end
      end

      applyStimulusA(1'b1);
      checkVal("firstEdgeA_h", ifA.o_h, -159);
      checkVal("firstEdgeA_frame", ifA.o_frame, 0);

      // Run the 640x480 instance through the vertical blanking into line 1.
      lastLine = -1;
      hsRun    = 0;
      vsLow    = 0;
      deLine0  = 0;
      for (int i = 0; i < 37000; i++) begin
         applyStimulusA(1'b1);
         if (ifA.o_line) begin
            if (lastLine >= 0) checkVal("lineSpacingA", nA - lastLine, 800);
            lastLine = nA;
         end
         if (!ifA.o_hs) begin
            if (hsRun == 0) checkVal("hsStartA", ifA.o_h, -144);
            hsRun++;
         end else if (hsRun > 0) begin
            checkVal("hsWidthA", hsRun, 96);
            hsRun = 0;
         end
         if (!ifA.o_vs) vsLow++;
         if (ifA.o_v == 16'sd0 && ifA.o_de) deLine0++;
         if (nA == 35999) begin
            checkVal("cornerA_h", ifA.o_h, 639);
            checkVal("cornerA_v", ifA.o_v, -1);
         end
         if (nA == 36000) begin
            checkVal("wrapA_h", ifA.o_h, -160);
            checkVal("wrapA_v", ifA.o_v, 0);
            checkVal("wrapA_line_de", {ifA.o_line, ifA.o_de}, 2);
         end
      end
      checkVal("vsWidthA", vsLow, 1600);
      checkVal("deLine0A", deLine0, 640);

      @(negedge clk);
      #3;
      resetA(3);
      repeat (10) applyStimulusA(1'b1);

      // Random 50% stalls over five full tiny frames.
      enCount    = 0;
      lineCount  = 0;
      frameCount = 0;
      for (int i = 0; i < 2000 && enCount < 175; i++) begin
         en = 1'($urandom_range(0, 1));
         applyStimulusB(en);
         if (en) begin
            enCount++;
            if (ifB.o_line) lineCount++;
            if (ifB.o_frame) frameCount++;
         end
      end
      checkVal("stallBudgetB", enCount, 175);
      checkVal("linesPer175B", lineCount, 25);
      checkVal("framesPer175B", frameCount, 5);

      @(negedge clk);
      #2;
      resetB(2);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (ifB.o_h == 16'sd3 && ifB.o_v == 16'sd1) found = 1'b1;
         else applyStimulusB(1'b1);
      end
      checkVal("wrapB_reach", found, 1);
      applyStimulusB(1'b1);
      checkVal("wrapB_h", ifB.o_h, -3);
      checkVal("wrapB_v", ifB.o_v, -3);
      checkVal("wrapB_frame", ifB.o_frame, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_timings.md
Name: display_timings

Overview:
Generates raster timing for the display output: horizontal/vertical position counters, sync pulses, data-enable and line/frame strobes. It sits directly upstream of the test card generators: its o_y drives the gradient card's i_y, and its sync/DE outputs go to the TMDS/VGA encoder alongside the card's colour. Runs entirely on the pixel clock, with an optional clock-enable for divided-pixel modes.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
V_POL, 0, vsync active level

Ports:
i_pix_clk  in  1  pixel clock; the only clock
i_rst_n  in  1  asynchronous, active-low reset
i_en  in  1  pixel strobe; counters and outputs advance only when high
o_hs  out  1  horizontal sync, level per H_POL
o_vs  out  1  vertical sync, level per V_POL
o_de  out  1  high when the position is in the active area
o_line  out  1  one-enabled-cycle strobe at start of each line (h == H_STA)
o_frame  out  1  one-enabled-cycle strobe at start of frame (h == H_STA and v == V_STA)
o_h  out  16  signed horizontal position, H_STA..H_RES-1
o_v  out  16  signed vertical position, V_STA..V_RES-1
o_x  out  16  unsigned active x: o_h when o_h >= 0, else 0
o_y  out  16  unsigned active y: o_v when o_v >= 0, else 0

Behaviour:
- Constants: H_STA = -(H_FP+H_SYNC+H_BP) and V_STA = -(V_FP+V_SYNC+V_BP), with 640x480 defaults -160 and -45. Line total is H_STA..H_RES-1 (800 clocks); frame total is 525 lines.
- Blanking order from H_STA: front porch, sync, back porch, active. Sync spans h in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1], which is -144..-49 for the defaults. Vertical sync spans v in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1], which is -35..-34. o_vs is a function of v only and changes at line boundaries.
- All outputs are registered and mutually aligned: in any cycle, o_hs/o_vs/o_de/o_line/o_frame/o_x/o_y describe the same (o_h, o_v) position. Decode from the next-position value so there is no extra skew.
- Advance rule, on each rising edge with i_en = 1:
  - if h == H_RES-1, then h <= H_STA and the v update applies; otherwise h <= h+1.
  - v update: if v == V_RES-1, then v <= V_STA; otherwise v <= v+1.
- i_en = 0 holds every register, including strobes. A strobe stays asserted across a stall and drops on the next enabled advance.
- Reset, asynchronous assertion of i_rst_n low, at any time including mid-frame:
  - h = H_STA, v = V_STA; o_h/o_v show these values.
  - o_x = o_y = 0, o_de = 0.
  - o_hs = ~H_POL, o_vs = ~V_POL.
  - o_line = 1 and o_frame = 1, since reset lands on the frame start position.
- Release is synchronous to the clock edge in the integration. The first enabled edge after release moves to h = H_STA+1.
- o_de = (h >= 0) && (v >= 0), compared as signed 16-bit.
- Width rules: parameters must satisfy H_RES + H_FP + H_SYNC + H_BP <= 32767, and the same for vertical. Out-of-range settings are an elaboration error.
- Each of H_FP/H_SYNC/H_BP/V_FP/V_SYNC/V_BP must be >= 1.

Decomposition:
- Shared package/header display_modes: parameter sets for 480p60, 720p60 and 1080p60 (RES/FP/SYNC/BP/POL). It also holds the matching gradient STEP values (2, 2, 3) so the timing block and test cards are configured from one place.
- No sub-module. The horizontal and vertical counters are two instances of the same compare/wrap logic, written inline.

Test Plan:
- Reset: hold i_rst_n low for 5 clocks, then release -> o_h = -160, o_v = -45, o_de = 0, o_hs = o_vs = 1, o_frame = 1; the first enabled edge gives o_h = -159 and o_frame = 0.
- Line timing at defaults: o_line is spaced every 800 clocks; o_hs is low for exactly 96 clocks starting at o_h = -144; o_de is high for 640 consecutive clocks per active line.
- Frame timing: o_frame is spaced every 420000 clocks; o_vs is low for 1600 clocks (lines -35..-34); total o_de count per frame is 307200; o_y runs 0..479 and o_x runs 0..639 during DE.
- Wrap corner: at (639, 479) the next edge gives (-160, -45) with o_frame = 1. At (639, -1) the next edge gives (-160, 0) with o_line = 1, o_de = 0.
- Enable stalls: drive i_en with a random 50% duty -> positions advance only on enabled cycles; o_line/o_frame counts per 420000 enabled cycles are 525 and 1; strobes hold through stalls.
- Reset mid-frame plus small config: assert i_rst_n at (300, 200) -> all outputs immediately return to the reset values. Rerun with H_RES=4, V_RES=2, all porches/syncs = 1, H_POL = V_POL = 1 -> line total 7, frame total 5 lines, hs high at h = -2.
